// File: rtl/axi4_lite_read_master_if.sv
// AXI4-Lite read channels (AR + R) between a read initiator and a responder.
interface axi4_lite_read_master_if #(
  parameter int ADDRESS_WIDTH = 2
);
  logic [ADDRESS_WIDTH-1:0] read_addr;
  logic [2:0]               read_prot;
  logic                     read_addr_valid;
  logic                     read_addr_ready;
  logic [31:0]              read_data;
  logic [1:0]               read_resp;
  logic                     read_data_valid;
  logic                     read_data_ready;

  modport master (
    output read_addr, read_prot, read_addr_valid, read_data_ready,
    input  read_addr_ready, read_data, read_resp, read_data_valid
  );

  modport slave (
    input  read_addr, read_prot, read_addr_valid, read_data_ready,
    output read_addr_ready, read_data, read_resp, read_data_valid
  );
endinterface

// File: rtl/axi4_lite_read_master.sv
// AXI4-Lite single-outstanding read initiator: core request -> AR -> R -> core response.
// Optional watchdog abort when AXI4_READ_TIMEOUT_EN is defined.
module axi4_lite_read_master #(
  parameter int ADDRESS_WIDTH  = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     axi_clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic [1:0]               rsp_resp,
  output logic                     busy,
  output logic [1:0]               fsm_state,
  axi4_lite_read_master_if.master  axi
);

  // Every channel transfers on a rising edge where valid & ready are both high;
  // a raised valid is held, with its payload stable, until that transfer happens.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  logic   wd_expired;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 2..65535");
  end

`ifdef AXI4_READ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;

  // Expiry lands on the TIMEOUT_CYCLES-th cycle spent in ADDR/DATA.
  assign wd_expired = (wd_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge axi_clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == IDLE && req_valid && req_ready) begin
      wd_cnt <= '0;
    end else if (state == ADDR || state == DATA) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  assign busy          = (state != IDLE);
  assign fsm_state     = state;
  assign axi.read_prot = 3'b000;

  always_ff @(posedge axi_clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      req_ready           <= 1'b0;
      rsp_valid           <= 1'b0;
      rsp_data            <= '0;
      rsp_resp            <= 2'b00;
      axi.read_addr       <= '0;
      axi.read_addr_valid <= 1'b0;
      axi.read_data_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready           <= 1'b0;
            axi.read_addr       <= req_addr;
            axi.read_addr_valid <= 1'b1;
            state               <= ADDR;
          end
        end
        ADDR: begin
          if (axi.read_addr_ready) begin
            axi.read_addr_valid <= 1'b0;
            axi.read_data_ready <= 1'b1;
            state               <= DATA;
          end else if (wd_expired) begin
            axi.read_addr_valid <= 1'b0;
            rsp_valid           <= 1'b1;
            rsp_data            <= '0;
            rsp_resp            <= 2'b10;
            state               <= RESP;
          end
        end
        DATA: begin
          // A beat arriving on the expiry cycle still completes normally.
          if (axi.read_data_valid) begin
            axi.read_data_ready <= 1'b0;
            rsp_valid           <= 1'b1;
            rsp_data            <= axi.read_data;
            rsp_resp            <= axi.read_resp;
            state               <= RESP;
          end else if (wd_expired) begin
            axi.read_data_ready <= 1'b0;
            rsp_valid           <= 1'b1;
            rsp_data            <= '0;
            rsp_resp            <= 2'b10;
            state               <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi4_lite_read_master.md
# axi4_lite_read_master

AXI4-Lite read initiator: accepts single-word read requests from local core logic, issues them on the AXI read address channel and returns the read data and response to the requester. It is the master-side counterpart of the team's AXI4-Lite read responder and drives its address/data channels directly. One transaction is outstanding at a time. An optional watchdog aborts reads that the responder never completes.

## Interface
- ADDRESS_WIDTH, 2: width of request and AXI read address.
- TIMEOUT_CYCLES, 256: watchdog limit in cycles; used only with AXI4_READ_TIMEOUT_EN; legal range 2..65535.

- axi_clk  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  1  core request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_addr  in  ADDRESS_WIDTH  read address, sampled on request handshake.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  core accepts response.
- rsp_data  out  32  read data.
- rsp_resp  out  2  AXI response code (00 OKAY, 10 SLVERR, 11 DECERR).
- busy  out  1  high in any state other than IDLE.
- read_addr  out  ADDRESS_WIDTH  AXI ARADDR.
- read_prot  out  3  AXI ARPROT, constant 3'b000.
- read_addr_valid  out  1  AXI ARVALID.
- read_addr_ready  in  1  AXI ARREADY.
- read_data  in  32  AXI RDATA.
- read_resp  in  2  AXI RRESP, qualified by read_data_valid.
- read_data_valid  in  1  AXI RVALID.
- read_data_ready  out  1  AXI RREADY.

## Operation
- FSM states IDLE, ADDR, DATA, RESP; all outputs registered or decoded from state only (no input-to-output combinational path).
- IDLE: req_ready=1. On req_valid: latch req_addr into read_addr, go ADDR.
- ADDR: read_addr_valid=1, read_addr stable. On read_addr_ready: go DATA. read_addr_valid never drops before handshake.
- DATA: read_data_ready=1. On read_data_valid: latch read_data/read_resp into rsp_data/rsp_resp, go RESP.
- RESP: rsp_valid=1, rsp_data/rsp_resp stable. On rsp_ready: go IDLE.
- read_data_valid outside DATA is ignored (read_data_ready low); no data latched.
- read_resp is passed through unmodified; no retry on error.
- Reset values: req_ready=0 during reset, 1 on first cycle after release (IDLE); rsp_valid=0, rsp_data=0, rsp_resp=00, busy=0, read_addr=0, read_addr_valid=0, read_data_ready=0, read_prot=000.
- Reset mid-transaction: return to IDLE at once; in-flight transaction abandoned, no response to core.

## Timing
- Request handshake at edge N -> read_addr_valid high after edge N.
- Zero-wait responder (read_addr_ready and read_data_valid high in first possible cycle): rsp_valid high after edge N+2; minimum latency 3 cycles request-to-response.
- rsp_ready held high: rsp_valid low 1 cycle, IDLE for 1 cycle, next request accepted; peak throughput 1 read / 4 cycles.
- Each responder wait cycle on AR or R adds exactly one cycle of latency.
- rsp_ready low: RESP held indefinitely, req_ready stays 0.

## Configuration
- AXI4_READ_TIMEOUT_EN defined: counter (width ceil(log2(TIMEOUT_CYCLES+1))) clears on entry to ADDR, increments each cycle in ADDR or DATA. When it reaches TIMEOUT_CYCLES without completion: drop read_addr_valid/read_data_ready, go RESP with rsp_data=0, rsp_resp=10. Handshake in the same cycle as expiry wins (normal completion). Late R beats after abort are ignored while not in DATA.
- Undefined: no counter; ADDR/DATA wait indefinitely; TIMEOUT_CYCLES unused.

## Test plan
- Zero-wait responder, req_addr=2'b01, read_data=32'hDEADBEEF, read_resp=00 -> rsp_valid 3 cycles after request, rsp_data=DEADBEEF, rsp_resp=00, read_addr=01 during ADDR.
- read_addr_ready delayed 4 cycles, read_data_valid delayed 2 -> read_addr_valid/read_addr stable throughout, rsp_valid after 9 cycles, data correct.
- read_resp=10 with read_data=32'h12345678 -> rsp_resp=10, rsp_data=12345678; rsp_ready held low 5 cycles -> rsp_valid and data stable, req_ready=0.
- Spurious read_data_valid in IDLE and ADDR -> read_data_ready stays 0, nothing latched; back-to-back requests with rsp_ready=1 -> one accepted every 4 cycles.
- reset pulse while in DATA -> all outputs at reset values immediately, IDLE after release, next read completes normally.
- AXI4_READ_TIMEOUT_EN, TIMEOUT_CYCLES=8, responder never asserts read_data_valid -> rsp_valid after 8 cycles in ADDR/DATA, rsp_resp=10, rsp_data=0; completion on expiry cycle -> normal response.
